uart_threshold_bank: RTL and testbench
======================================

UART_THRESHOLD_BANK -- requirements
Module: uart_threshold_bank

Interface
REQ-001 Parameter NUM_CH, default 7: number of threshold channels, legal range 1..26.
REQ-002 Parameter TH_WIDTH, default 16: bits per threshold, a multiple of 8 in the range 8..32.
REQ-003 Parameter TH_SIGNED, default 1: 1 means thresholds are two's-complement, 0 means unsigned.
REQ-004 Parameters CH_MIN, CH_MAX, CH_STEP, CH_DEFAULT, each NUM_CH*TH_WIDTH bits, channel i in slice [i*TH_WIDTH +: TH_WIDTH]; defaults per channel as {min, max, step, default}:
- ch0 = {50, 5000, 50, 2550};
- odd ch = {32, 50, 1, 35};
- even ch>=2 = {-12, 27, 1, 16}.
REQ-005 clk  in  1  sole clock; all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rx_data  in  8  received byte.
REQ-008 rx_valid  in  1  one-cycle pulse, rx_data valid.
REQ-009 tx_idle  in  1  transmitter can accept a byte.
REQ-010 tx_data  out  8  byte to transmit, registered.
REQ-011 tx_start  out  1  one-cycle start pulse, registered.
REQ-012 th_flat  out  NUM_CH*TH_WIDTH  all thresholds, channel i in slice [i*TH_WIDTH +: TH_WIDTH].
REQ-013 sel  out  5  currently selected channel index.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 cmd_drop  out  1  one-cycle pulse when an rx byte is discarded.

Function
REQ-016 The FSM SHALL have the states IDLE, ECHO, ADJUST, TX_BYTE and TX_GAP.
REQ-017 In IDLE, when rx_valid is high, bytes SHALL be decoded as follows:
- "A"+i, for i<NUM_CH: select command;
- "w": increment command;
- "s": decrement command;
- "?": read-back command;
- any other byte: ignored, no state change, no cmd_drop.
REQ-018 A recognised command SHALL be latched and the FSM SHALL move to ECHO on the next cycle.
REQ-019 In ECHO, in the first cycle with tx_idle high, the block SHALL drive tx_start=1 and tx_data=the latched command byte, then move to the next state:
- select command: sel updated, then IDLE;
- "w" or "s": ADJUST;
- "?": TX_BYTE with byte index 0.
REQ-020 ECHO SHALL wait indefinitely while tx_idle is low.
REQ-021 ADJUST SHALL last exactly one cycle and update channel sel with saturation, computed in TH_WIDTH+1 bits with signedness per TH_SIGNED:
- increment: value = min(value+step, max);
- decrement: value = max(value-step, min).
REQ-022 ADJUST SHALL go to TX_BYTE with byte index 0.
REQ-023 TX_BYTE SHALL wait for tx_idle, then pulse tx_start with byte k of the selected threshold (LSB first), then go to TX_GAP.
REQ-024 TX_GAP SHALL last exactly one cycle, then:
- if k < TH_WIDTH/8-1: increment k and return to TX_BYTE;
- otherwise: return to IDLE.
REQ-025 The value transmitted SHALL be the post-ADJUST value.
REQ-026 The bytes SHALL be taken from a snapshot latched on entering TX_BYTE with k=0.
REQ-027 Every rx_valid that arrives while busy=1 SHALL be discarded and SHALL pulse cmd_drop on the following cycle.
REQ-028 rx_valid in the same cycle the FSM returns to IDLE SHALL be discarded.
REQ-029 tx_start SHALL never be high on two consecutive cycles.
REQ-030 tx_data SHALL be 0 whenever tx_start is 0.
REQ-031 A select command with i>=NUM_CH SHALL be treated as unrecognised.

Reset
REQ-032 On a clk edge with rst=1, the outputs SHALL take these values:
- state = IDLE, sel = 0, k = 0;
- tx_start = 0, tx_data = 0, cmd_drop = 0;
- every channel = CH_DEFAULT.
REQ-033 A rst asserted mid-transmission SHALL abort the transmission with no further tx_start.
REQ-034 The first command SHALL be accepted on the first cycle after rst deasserts.

Configuration
REQ-035 With macro UART_CMD_ECHO_EN defined, ECHO SHALL behave as specified in REQ-019 and REQ-020.
REQ-036 With UART_CMD_ECHO_EN undefined, ECHO SHALL not wait and SHALL not pulse tx_start; it SHALL pass directly to its successor state in one cycle.

Verification
REQ-037 Reset, then "w", with defaults and echo enabled:
- -> echo 0x77;
- -> ch0 = 2600;
- -> bytes 0x28, 0x0A sent;
- -> busy back to 0.
REQ-038 "B", then 20x "w" -> ch1 saturates at 50; last two read-backs each 0x32, 0x00.
REQ-039 "C", then 30x "s" -> ch2 saturates at -12; bytes 0xF4, 0xFF.
REQ-040 "?" with tx_idle held low for 100 cycles, then high -> no tx_start while low; echo sent, then value bytes, in order.
REQ-041 "w", then "w" 3 cycles later -> second "w" dropped; cmd_drop pulses once; ch0 = 2600.
REQ-042 Byte "Z" (NUM_CH=7), then rst asserted during TX_BYTE -> "Z" ignored with no cmd_drop; after rst: all channels default, sel = 0, no tx_start.

Source files
------------

// File: rtl/uart_threshold_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_threshold_bank
// Brief    : UART byte-command front end for a bank of saturating thresholds
//            (select / increment / decrement / read-back, LSB-first replies).
// Options  : UART_CMD_ECHO_EN - echo every accepted command byte before acting
// Revision : 1.0 - initial release
// ============================================================================
module uart_threshold_bank #(
    parameter int NUM_CH    = 7,
    parameter int TH_WIDTH  = 16,
    parameter int TH_SIGNED = 1,
    // ch0 is special; ch1.. alternate odd/even patterns (LSB channel first)
    parameter logic [NUM_CH*TH_WIDTH-1:0] CH_MIN =
        (NUM_CH*TH_WIDTH)'({{(NUM_CH/2+1){TH_WIDTH'(-12), TH_WIDTH'(32)}}, TH_WIDTH'(50)}),
    parameter logic [NUM_CH*TH_WIDTH-1:0] CH_MAX =
        (NUM_CH*TH_WIDTH)'({{(NUM_CH/2+1){TH_WIDTH'(27), TH_WIDTH'(50)}}, TH_WIDTH'(5000)}),
    parameter logic [NUM_CH*TH_WIDTH-1:0] CH_STEP =
        (NUM_CH*TH_WIDTH)'({{(NUM_CH/2+1){TH_WIDTH'(1), TH_WIDTH'(1)}}, TH_WIDTH'(50)}),
    parameter logic [NUM_CH*TH_WIDTH-1:0] CH_DEFAULT =
        (NUM_CH*TH_WIDTH)'({{(NUM_CH/2+1){TH_WIDTH'(16), TH_WIDTH'(35)}}, TH_WIDTH'(2550)})
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    input  logic                         tx_idle,
    output logic [7:0]                   tx_data,
    output logic                         tx_start,
    output logic [NUM_CH*TH_WIDTH-1:0]   th_flat,
    output logic [4:0]                   sel,
    output logic                         busy,
    output logic                         cmd_drop
);

    localparam logic [7:0] c_CMD_INC  = 8'h77;
    localparam logic [7:0] c_CMD_DEC  = 8'h73;
    localparam logic [7:0] c_CMD_READ = 8'h3F;
    localparam logic [7:0] c_CMD_SEL0 = 8'h41;
    localparam logic [7:0] c_SEL_END  = 8'(8'h41 + NUM_CH);
    localparam logic [1:0] c_LAST_K   = 2'(TH_WIDTH/8 - 1);
    localparam logic       c_SIGNED   = (TH_SIGNED != 0);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ECHO    = 3'd1,
        ST_ADJUST  = 3'd2,
        ST_TX_BYTE = 3'd3,
        ST_TX_GAP  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [7:0]            r_cmd;
    logic [4:0]            r_sel;
    logic [1:0]            r_k;
    logic [1:0]            w_k_nx;
    logic [TH_WIDTH-1:0]   r_snap;
    logic                  r_tx_start;
    logic [7:0]            r_tx_data;
    logic                  r_cmd_drop;

    logic                  w_rx_cmd;
    logic                  w_is_inc;
    logic                  w_is_dec;
    logic                  w_is_read;
    logic [4:0]            w_cmd_idx;
    logic [7:0]            w_byte;

    logic                  w_latch;
    logic                  w_advance;
    logic                  w_fire;
    logic [7:0]            w_fire_data;
    logic                  w_sel_we;
    logic                  w_adj_we;
    logic                  w_snap_we;
    logic                  w_snap_from_adj;

    logic [TH_WIDTH-1:0]   w_cur_t  [NUM_CH];
    logic [TH_WIDTH-1:0]   w_min_t  [NUM_CH];
    logic [TH_WIDTH-1:0]   w_max_t  [NUM_CH];
    logic [TH_WIDTH-1:0]   w_step_t [NUM_CH];
    logic [TH_WIDTH-1:0]   w_cur;
    logic [TH_WIDTH-1:0]   w_min;
    logic [TH_WIDTH-1:0]   w_max;
    logic [TH_WIDTH-1:0]   w_step;

    logic [TH_WIDTH:0]     w_cur_x;
    logic [TH_WIDTH:0]     w_min_x;
    logic [TH_WIDTH:0]     w_max_x;
    logic [TH_WIDTH:0]     w_step_x;
    logic [TH_WIDTH:0]     w_sum;
    logic [TH_WIDTH:0]     w_dif;
    logic                  w_over;
    logic                  w_under;
    logic [TH_WIDTH-1:0]   w_adj_val;

    assign w_rx_cmd  = (rx_data == c_CMD_INC) || (rx_data == c_CMD_DEC) ||
                       (rx_data == c_CMD_READ) ||
                       ((rx_data >= c_CMD_SEL0) && (rx_data < c_SEL_END));
    assign w_is_inc  = (r_cmd == c_CMD_INC);
    assign w_is_dec  = (r_cmd == c_CMD_DEC);
    assign w_is_read = (r_cmd == c_CMD_READ);
    assign w_cmd_idx = 5'(r_cmd - c_CMD_SEL0);
    assign w_byte    = 8'(r_snap >> {r_k, 3'b000});

    // Per-channel storage; the selected channel is exposed as masked terms
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [TH_WIDTH-1:0] c_MIN  = CH_MIN    [i*TH_WIDTH +: TH_WIDTH];
        localparam logic [TH_WIDTH-1:0] c_MAX  = CH_MAX    [i*TH_WIDTH +: TH_WIDTH];
        localparam logic [TH_WIDTH-1:0] c_STEP = CH_STEP   [i*TH_WIDTH +: TH_WIDTH];
        localparam logic [TH_WIDTH-1:0] c_DEF  = CH_DEFAULT[i*TH_WIDTH +: TH_WIDTH];

        logic [TH_WIDTH-1:0] r_val;
        logic                w_hit;

        assign w_hit = (r_sel == 5'(i));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_val <= c_DEF;
            end else if (w_adj_we && w_hit) begin
                r_val <= w_adj_val;
            end
        end

        assign th_flat[i*TH_WIDTH +: TH_WIDTH] = r_val;
        assign w_cur_t[i]  = w_hit ? r_val  : '0;
        assign w_min_t[i]  = w_hit ? c_MIN  : '0;
        assign w_max_t[i]  = w_hit ? c_MAX  : '0;
        assign w_step_t[i] = w_hit ? c_STEP : '0;
    end

    always_comb begin
        w_cur  = '0;
        w_min  = '0;
        w_max  = '0;
        w_step = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cur  = w_cur  | w_cur_t[i];
            w_min  = w_min  | w_min_t[i];
            w_max  = w_max  | w_max_t[i];
            w_step = w_step | w_step_t[i];
        end
    end

    // One extra bit keeps the sum/difference from wrapping before the clamp
    assign w_cur_x  = {c_SIGNED & w_cur[TH_WIDTH-1],  w_cur};
    assign w_min_x  = {c_SIGNED & w_min[TH_WIDTH-1],  w_min};
    assign w_max_x  = {c_SIGNED & w_max[TH_WIDTH-1],  w_max};
    assign w_step_x = {c_SIGNED & w_step[TH_WIDTH-1], w_step};
    assign w_sum    = w_cur_x + w_step_x;
    assign w_dif    = w_cur_x - w_step_x;
    // Unsigned sums can reach 2^TH_WIDTH, so only the difference is read as signed there
    assign w_over   = c_SIGNED ? ($signed(w_sum) > $signed(w_max_x)) : (w_sum > w_max_x);
    assign w_under  = $signed(w_dif) < $signed(w_min_x);
    assign w_adj_val = w_is_inc ? (w_over  ? w_max : w_sum[TH_WIDTH-1:0])
                                : (w_under ? w_min : w_dif[TH_WIDTH-1:0]);

    always_comb begin
        w_state_nx      = r_state;
        w_k_nx          = r_k;
        w_latch         = 1'b0;
        w_advance       = 1'b0;
        w_fire          = 1'b0;
        w_fire_data     = 8'h00;
        w_sel_we        = 1'b0;
        w_adj_we        = 1'b0;
        w_snap_we       = 1'b0;
        w_snap_from_adj = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid && w_rx_cmd) begin
                    w_latch    = 1'b1;
                    w_state_nx = ST_ECHO;
                end
            end
            ST_ECHO: begin
`ifdef UART_CMD_ECHO_EN
                w_advance   = tx_idle && !r_tx_start;
                w_fire      = w_advance;
                w_fire_data = r_cmd;
`else
                w_advance   = 1'b1;
`endif
                if (w_advance) begin
                    if (w_is_inc || w_is_dec) begin
                        w_state_nx = ST_ADJUST;
                    end else if (w_is_read) begin
                        w_state_nx = ST_TX_BYTE;
                        w_k_nx     = 2'd0;
                        w_snap_we  = 1'b1;
                    end else begin
                        w_sel_we   = 1'b1;
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            ST_ADJUST: begin
                w_adj_we        = 1'b1;
                w_snap_we       = 1'b1;
                w_snap_from_adj = 1'b1;
                w_k_nx          = 2'd0;
                w_state_nx      = ST_TX_BYTE;
            end
            ST_TX_BYTE: begin
                // r_tx_start guard keeps a gap after an echo issued the cycle before
                if (tx_idle && !r_tx_start) begin
                    w_fire      = 1'b1;
                    w_fire_data = w_byte;
                    w_state_nx  = ST_TX_GAP;
                end
            end
            ST_TX_GAP: begin
                if (r_k < c_LAST_K) begin
                    w_k_nx     = r_k + 2'd1;
                    w_state_nx = ST_TX_BYTE;
                end else begin
                    w_k_nx     = 2'd0;
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_k_nx     = 2'd0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cmd      <= 8'h00;
            r_sel      <= 5'd0;
            r_k        <= 2'd0;
            r_snap     <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_cmd_drop <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_k        <= w_k_nx;
            r_tx_start <= w_fire;
            r_tx_data  <= w_fire ? w_fire_data : 8'h00;
            r_cmd_drop <= rx_valid && (r_state != ST_IDLE);
            if (w_latch) begin
                r_cmd <= rx_data;
            end
            if (w_sel_we) begin
                r_sel <= w_cmd_idx;
            end
            if (w_snap_we) begin
                r_snap <= w_snap_from_adj ? w_adj_val : w_cur;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;
    assign sel      = r_sel;
    assign busy     = (r_state != ST_IDLE);
    assign cmd_drop = r_cmd_drop;

endmodule
`default_nettype wire

// File: tb/tb_uart_threshold_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_threshold_bank
// Brief    : Self-checking bench: command vector table plus transmit scoreboard.
// Options  : UART_CMD_ECHO_EN - expects echoed command bytes when defined
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_threshold_bank;

    localparam int NUM_CH   = 7;
    localparam int TH_WIDTH = 16;
`ifdef UART_CMD_ECHO_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif

    logic                       clk      = 1'b0;
    logic                       rst      = 1'b1;
    logic [7:0]                 rx_data  = 8'h00;
    logic                       rx_valid = 1'b0;
    logic                       tx_idle  = 1'b1;
    logic [7:0]                 tx_data;
    logic                       tx_start;
    logic [NUM_CH*TH_WIDTH-1:0] th_flat;
    logic [4:0]                 sel;
    logic                       busy;
    logic                       cmd_drop;

    uart_threshold_bank dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_idle  (tx_idle),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .th_flat  (th_flat),
        .sel      (sel),
        .busy     (busy),
        .cmd_drop (cmd_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        int         sel;
        int         val;
        bit         rd;
        bit         rec;
    } vec_t;

    int         n_total = 0;
    int         n_pass  = 0;
    int         n_start = 0;
    int         n_drop  = 0;
    bit         mon_en  = 1'b0;
    bit         prev_start = 1'b0;
    logic [7:0] exp_q[$];
    int         def_val [NUM_CH] = '{2550, 35, 16, 35, 16, 35, 16};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] ch(input int i);
        return 16'(th_flat >> (i * TH_WIDTH));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        chk(name, 32'(done), 32'd1);
        tick();
    endtask

    task automatic push_cmd(input logic [7:0] cmd, input bit rd, input int val);
        if (ECHO_EN) exp_q.push_back(cmd);
        if (rd) begin
            exp_q.push_back(8'(val));
            exp_q.push_back(8'(val >> 8));
        end
    endtask

    task automatic chk_defaults(input string tag);
        for (int i = 0; i < NUM_CH; i++) chk({tag, "_ch"}, 32'(ch(i)), 32'(16'(def_val[i])));
        chk({tag, "_sel"}, 32'(sel), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Transmit monitor: every start pulse pops one expected byte
    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_start) begin
                n_start++;
                chk("tx_no_back_to_back", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL tx_unexpected: got tx_start with 0x%0h, expected none", tx_data);
                end else begin
                    chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("tx_data_zero", 32'(tx_data), 32'd0);
            end
            prev_start = tx_start;
            if (cmd_drop) n_drop++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within 1 ms");
        $fatal(1);
    end

    initial begin
        vec_t tbl[13];
        int   v;
        int   d0;
        int   s0;

        tbl = '{
            '{8'h77, 0, 2600, 1'b1, 1'b1},
            '{8'h73, 0, 2550, 1'b1, 1'b1},
            '{8'h42, 1,   35, 1'b0, 1'b1},
            '{8'h77, 1,   36, 1'b1, 1'b1},
            '{8'h43, 2,   16, 1'b0, 1'b1},
            '{8'h73, 2,   15, 1'b1, 1'b1},
            '{8'h3F, 2,   15, 1'b1, 1'b1},
            '{8'h41, 0, 2550, 1'b0, 1'b1},
            '{8'h3F, 0, 2550, 1'b1, 1'b1},
            '{8'h48, 0, 2550, 1'b0, 1'b0},
            '{8'h47, 6,   16, 1'b0, 1'b1},
            '{8'h77, 6,   17, 1'b1, 1'b1},
            '{8'h78, 6,   17, 1'b0, 1'b0}
        };

        repeat (3) tick();
        mon_en = 1'b1;
        chk_defaults("reset");
        chk("reset_tx_start", 32'(tx_start), 32'd0);
        chk("reset_tx_data", 32'(tx_data), 32'd0);
        chk("reset_cmd_drop", 32'(cmd_drop), 32'd0);
        rst = 1'b0;

        // First vector is driven in the very first cycle after reset release
        for (int t = 0; t < 13; t++) begin
            d0 = n_drop;
            if (tbl[t].rec) push_cmd(tbl[t].cmd, tbl[t].rd, tbl[t].val);
            send(tbl[t].cmd);
            wait_idle("vec_done");
            chk("vec_sel", 32'(sel), 32'(tbl[t].sel));
            chk("vec_val", 32'(ch(tbl[t].sel)), 32'(16'(tbl[t].val)));
            chk("vec_sb_empty", 32'(exp_q.size()), 32'd0);
            chk("vec_no_drop", 32'(n_drop - d0), 32'd0);
        end

        // Increment saturation on ch1
        push_cmd(8'h42, 1'b0, 0);
        send(8'h42);
        wait_idle("sat_inc_sel");
        v = 36;
        for (int n = 0; n < 20; n++) begin
            v = (v + 1 > 50) ? 50 : v + 1;
            push_cmd(8'h77, 1'b1, v);
            send(8'h77);
            wait_idle("sat_inc_done");
        end
        chk("sat_inc_ch1", 32'(ch(1)), 32'd50);
        chk("sat_inc_sb_empty", 32'(exp_q.size()), 32'd0);

        // Decrement saturation on ch2 into negative range
        push_cmd(8'h43, 1'b0, 0);
        send(8'h43);
        wait_idle("sat_dec_sel");
        v = 15;
        for (int n = 0; n < 30; n++) begin
            v = (v - 1 < -12) ? -12 : v - 1;
            push_cmd(8'h73, 1'b1, v);
            send(8'h73);
            wait_idle("sat_dec_done");
        end
        chk("sat_dec_ch2", 32'(ch(2)), 32'h0000_FFF4);
        chk("sat_dec_sb_empty", 32'(exp_q.size()), 32'd0);

        // Second command while busy is dropped
        push_cmd(8'h41, 1'b0, 0);
        send(8'h41);
        wait_idle("drop_sel");
        d0 = n_drop;
        push_cmd(8'h77, 1'b1, 2600);
        send(8'h77);
        tick();
        tick();
        send(8'h77);
        wait_idle("drop_done");
        chk("drop_count", 32'(n_drop - d0), 32'd1);
        chk("drop_ch0", 32'(ch(0)), 32'd2600);
        chk("drop_sb_empty", 32'(exp_q.size()), 32'd0);

        // Read-back held off by tx_idle low
        tx_idle = 1'b0;
        s0 = n_start;
        push_cmd(8'h3F, 1'b1, 2600);
        send(8'h3F);
        repeat (100) tick();
        chk("hold_no_start", 32'(n_start - s0), 32'd0);
        tx_idle = 1'b1;
        wait_idle("hold_done");
        chk("hold_starts", 32'(n_start - s0), ECHO_EN ? 32'd3 : 32'd2);
        chk("hold_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset then ignored byte, then reset mid read-back
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_defaults("rst2");
        d0 = n_drop;
        send(8'h5A);
        tick();
        tick();
        chk("z_busy", 32'(busy), 32'd0);
        chk("z_no_drop", 32'(n_drop - d0), 32'd0);

        tx_idle = 1'b0;
        if (ECHO_EN) exp_q.push_back(8'h3F);
        send(8'h3F);
        repeat (5) tick();
        if (ECHO_EN) begin
            tx_idle = 1'b1;
            tick();
            tx_idle = 1'b0;
            repeat (5) tick();
        end
        chk("abort_busy_before", 32'(busy), 32'd1);
        s0 = n_start;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tx_idle = 1'b1;
        repeat (20) tick();
        chk("abort_no_start", 32'(n_start - s0), 32'd0);
        chk_defaults("abort");
        chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
